// File: rtl/hamming_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : hamming_seq_unit
// Purpose  : Multi-cycle bit-count engine. Counts a WIDTH-bit operand CHUNK
//            bits per cycle under a start/done handshake. Modes: popcount(a),
//            popcount(a^b) (Hamming distance), parity(a), zero count of a.
//            With EARLY_EXIT=1 the count stops as soon as the remaining
//            shifted operand is zero.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset
//            start  - request, accepted only while busy=0
//            mode   - 00 popcount(a), 01 popcount(a^b), 10 parity(a),
//                     11 WIDTH-popcount(a)
//            a, b   - operands (b used only in mode 01)
//            busy   - high whenever the engine is not idle
//            done   - one-cycle pulse, result valid in that cycle
//            result - final count, held until next accepted start or reset
// Revision : 1.0 - initial release
// ============================================================================
module hamming_seq_unit #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] result
);

    localparam int N  = WIDTH / CHUNK;
    localparam int RW = $clog2(WIDTH + 1);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_op;
    logic [RW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_mode;
    logic [RW-1:0]    r_result;

    logic [RW-1:0]    w_pop;
    logic [RW-1:0]    w_acc_next;
    logic [WIDTH-1:0] w_op_shift;
    logic             w_last;
    logic [RW-1:0]    w_res;

    // When one chunk covers the whole operand, nothing remains after a shift.
    generate
        if (CHUNK == WIDTH) begin : g_shift_all
            assign w_op_shift = '0;
        end else begin : g_shift_chunk
            assign w_op_shift = r_op >> CHUNK;
        end
    endgenerate

    // Per-chunk population count of the low CHUNK bits.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_pop = w_pop + RW'(r_op[i]);
        end
    end

    assign w_acc_next = r_acc + w_pop;
    assign w_last     = (r_cnt == c_last_cnt) ||
                        ((EARLY_EXIT != 0) && (w_op_shift == '0));

    // Final result formed from the accumulator value that enters DONE.
    always_comb begin
        w_res = w_acc_next;
        case (r_mode)
            2'b10:   w_res = {{(RW-1){1'b0}}, w_acc_next[0]};
            2'b11:   w_res = RW'(WIDTH) - w_acc_next;
            default: w_res = w_acc_next;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mode   <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= (mode == 2'b01) ? (a ^ b) : a;
                        r_mode <= mode;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_op  <= w_op_shift;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_hamming_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_seq_unit
// Purpose  : Directed self-checking bench for hamming_seq_unit. Two instances
//            (EARLY_EXIT=0 and EARLY_EXIT=1, WIDTH=32, CHUNK=8) share clock,
//            reset and operand inputs; each has its own start.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hamming_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0;
    logic        start1;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy0, done0, busy1, done1;
    logic [5:0]  res0, res1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [5:0] last0 = '0;
    logic [5:0] last1 = '0;

    always #5 clk = ~clk;

    hamming_seq_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_ee0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode), .a(a), .b(b),
        .busy(busy0), .done(done0), .result(res0)
    );

    hamming_seq_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(res1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, busy span, result hold and result.
    task automatic run_op(input bit ee, input logic [1:0] m, input logic [31:0] av,
                          input logic [31:0] bv, input logic [5:0] exp_res,
                          input int exp_lat, input string tag);
        int   cyc;
        int   nbusy;
        bit   seen;
        logic [5:0] prev;
        prev = ee ? last1 : last0;
        mode = m; a = av; b = bv;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0; start1 = 1'b0;
        cyc = 1; nbusy = 0; seen = 1'b0;
        chk({tag, "_hold"}, ee ? res1 : res0, prev);
        while (!seen && cyc <= 20) begin
            if (ee ? busy1 : busy0) nbusy++;
            if (ee ? done1 : done0) seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_busy"}, nbusy, exp_lat);
        chk({tag, "_res"}, ee ? res1 : res0, exp_res);
        if (ee) last1 = exp_res; else last0 = exp_res;
        step();
    endtask

    initial begin : main
        int ndone;
        int cyc2;
        logic [5:0] r2;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 2'b00; a = '0; b = '0;
        step();
        step();
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_res0",  res0,  0);
        chk("rst_busy1", busy1, 0);
        chk("rst_res1",  res1,  0);
        rst = 1'b0;
        step();

        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0,         6'd32, 5, "pop_ones");
        run_op(0, 2'b01, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 6'd32, 5, "hd_full");
        run_op(0, 2'b01, 32'h1234_5678, 32'h1234_5678, 6'd0,  5, "hd_equal");
        run_op(0, 2'b10, 32'h0000_0007, 32'hFFFF_FFFF, 6'd1,  5, "parity7");
        run_op(0, 2'b11, 32'h0000_000F, 32'h0,         6'd28, 5, "zeros_f");

        // Second start two cycles after acceptance must be ignored.
        mode = 2'b00; a = 32'h0000_0001; start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        a = 32'hFFFF_FFFF; mode = 2'b11; start0 = 1'b1;
        step();
        start0 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done0) ndone++;
            step();
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_res", res0, 1);
        last0 = 6'd1;

        // Start held high: two back-to-back operations.
        mode = 2'b00; a = 32'h0000_0003; start0 = 1'b1;
        step();
        ndone = 0; cyc2 = 0; r2 = '0;
        for (int c = 1; c <= 12; c++) begin
            if (done0) begin
                ndone++;
                if (ndone == 1) a = 32'h0000_000F;
                if (ndone == 2) begin
                    cyc2 = c;
                    r2 = res0;
                    start0 = 1'b0;
                end
            end
            step();
        end
        start0 = 1'b0;
        chk("held_ndone", ndone, 2);
        chk("held_cyc2", cyc2, 11);
        chk("held_res2", r2, 4);
        step();
        last0 = 6'd4;

        // Reset during the third RUN cycle aborts the operation.
        mode = 2'b11; a = 32'h0000_000F; start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_res",  res0,  0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done0) ndone++;
            step();
        end
        chk("abort_ndone", ndone, 0);
        last0 = '0;
        last1 = '0;
        run_op(0, 2'b00, 32'h8000_0001, 32'h0, 6'd2, 5, "after_abort");

        run_op(1, 2'b00, 32'h0000_00FF, 32'h0, 6'd8, 2, "ee_low_byte");
        run_op(1, 2'b00, 32'h8000_0000, 32'h0, 6'd1, 5, "ee_msb");
        run_op(1, 2'b00, 32'h0000_0000, 32'h0, 6'd0, 2, "ee_zero");
        run_op(1, 2'b11, 32'h0000_0F00, 32'h0, 6'd28, 3, "ee_zeros");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
